// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux: forced-select, fixed-priority or round-robin grant into one output register.
// Latency: 1 cycle from input handshake to out_valid; one word per cycle while out_ready is high.
// Backpressure: the output word holds and in_ready is all-0 while out_valid=1 and out_ready=0.
module stream_mux_arb #(
    parameter  int WIDTH = 16,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [1:0]         mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SELW-1:0]    out_chan,
    input  logic               out_ready
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_data;
    logic [SELW-1:0]   r_chan;
    logic [SELW-1:0]   r_ptr;

    logic [N-1:0]      w_grant;
    logic [SELW-1:0]   w_idx;
    logic [WIDTH-1:0]  w_dat;
    logic              w_load_en;
    logic              w_xfer;

    // Grant is derived only from valids, mode, sel and the RR pointer, so
    // out_ready never feeds back into the arbitration itself.
    always_comb begin
        int j;
        w_grant = '0;
        w_idx   = '0;
        j       = 0;
        case (mode)
            2'b00: begin
                if (int'(sel) < N) begin
                    w_grant[sel] = in_valid[sel];
                    w_idx        = sel;
                end
            end
            2'b10: begin
                // Walk the search order backwards so the nearest valid after ptr wins.
                for (int k = N; k >= 1; k--) begin
                    j = (int'(r_ptr) + k) % N;
                    if (in_valid[j]) begin
                        w_grant    = '0;
                        w_grant[j] = 1'b1;
                        w_idx      = SELW'(j);
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_grant    = '0;
                        w_grant[i] = 1'b1;
                        w_idx      = SELW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_dat = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign w_load_en = !out_valid || out_ready;
    assign in_ready  = rst_n ? (w_grant & {N{w_load_en}}) : '0;
    assign w_xfer    = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready && !w_xfer) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // The pointer follows every transfer so a later switch to round-robin stays fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= SELW'(N - 1);
        end else if (w_xfer) begin
            r_data <= w_dat;
            r_chan <= w_idx;
            r_ptr  <= w_idx;
        end
    end

    assign out_data = r_data;
    assign out_chan = r_chan;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: a 4-channel instance checked through an expected-word queue,
// plus a 3-channel instance for the out-of-range forced select.
module tb_stream_mux_arb;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic        out_ready;

    logic        rst2_n;
    logic [47:0] in_data2;
    logic [2:0]  in_valid2;
    logic [2:0]  in_ready2;
    logic [1:0]  mode2;
    logic [1:0]  sel2;
    logic [15:0] out_data2;
    logic        out_valid2;
    logic [1:0]  out_chan2;
    logic        out_ready2;

    logic [15:0] ch_data [4];
    exp_t        q [$];
    int          checks;
    int          errors;

    stream_mux_arb #(.WIDTH(16), .N(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    stream_mux_arb #(.WIDTH(16), .N(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .mode      (mode2),
        .sel       (sel2),
        .out_data  (out_data2),
        .out_valid (out_valid2),
        .out_chan  (out_chan2),
        .out_ready (out_ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: at the falling edge compare the held word against the queue head,
    // check in_ready, queue the word the bench expects to be accepted, then step past the rising edge.
    task automatic step(input logic [3:0] exp_rdy, input string tag);
        exp_t e;
        @(negedge clk);
        chk({tag, "_vld"}, 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, "_dat"}, 32'(out_data), 32'(q[0].d));
            chk({tag, "_chan"}, 32'(out_chan), 32'(q[0].c));
            if (out_ready) begin
                void'(q.pop_front());
            end
        end
        chk({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                e.d = ch_data[i];
                e.c = 2'(i);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        ch_data[0] = 16'h1111;
        ch_data[1] = 16'h2222;
        ch_data[2] = 16'h3333;
        ch_data[3] = 16'h4444;
        rst_n      = 1'b0;
        mode       = 2'b00;
        sel        = 2'd0;
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
        rst2_n     = 1'b0;
        in_data2   = {16'h7777, 16'h6666, 16'h5555};
        in_valid2  = 3'b111;
        mode2      = 2'b00;
        sel2       = 2'd0;
        out_ready2 = 1'b1;

        #1;
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_dat",   32'(out_data),  32'd0);
        chk("rst_chan",  32'(out_chan),  32'd0);
        chk("rst_rdy",   32'(in_ready),  32'd0);
        chk("rst3_rdy",  32'(in_ready2), 32'd0);

        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin from reset: first search starts at channel 0, no bubbles.
        mode     = 2'b10;
        in_valid = 4'b1111;
        step(4'b0001, "rr0");
        step(4'b0010, "rr1");
        step(4'b0100, "rr2");
        step(4'b1000, "rr3");
        step(4'b0001, "rr4");

        // Forced select on channel 2, repeated every cycle.
        mode = 2'b00;
        sel  = 2'd2;
        step(4'b0100, "frc0");
        step(4'b0100, "frc1");
        step(4'b0100, "frc2");

        // Backpressure: hold 0x1111 for three cycles, then release.
        sel = 2'd0;
        step(4'b0001, "bp_load");
        out_ready = 1'b0;
        step(4'b0000, "bp_hold0");
        step(4'b0000, "bp_hold1");
        step(4'b0000, "bp_hold2");
        out_ready = 1'b1;
        mode      = 2'b10;
        step(4'b0010, "bp_rel");

        // Fixed priority with ch0/ch3, then switch to round-robin after ptr=0.
        mode     = 2'b01;
        in_valid = 4'b1001;
        step(4'b0001, "fp0");
        step(4'b0001, "fp1");
        mode = 2'b10;
        step(4'b1000, "sw_rr0");
        step(4'b0001, "sw_rr1");

        // Reset while holding 0x2222: outputs clear without a clock edge.
        mode     = 2'b00;
        sel      = 2'd1;
        in_valid = 4'b1111;
        step(4'b0010, "mid_load");
        out_ready = 1'b0;
        step(4'b0000, "mid_hold");
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld",  32'(out_valid), 32'd0);
        chk("mid_rst_dat",  32'(out_data),  32'd0);
        chk("mid_rst_chan", 32'(out_chan),  32'd0);
        chk("mid_rst_rdy",  32'(in_ready),  32'd0);
        q.delete();
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mode     = 2'b10;
        in_valid = 4'b1111;
        step(4'b0001, "post_rr0");
        step(4'b0010, "post_rr1");

        // Drain: no valids, output empties but data keeps its last value.
        in_valid = 4'b0000;
        step(4'b0000, "drain0");
        step(4'b0000, "drain1");
        chk("drain_keep_dat", 32'(out_data), 32'h2222);

        // N=3: sel=3 is out of range and must never grant.
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        sel2 = 2'd1;
        @(negedge clk);
        chk("n3_rdy_sel1", 32'(in_ready2), 32'b010);
        @(posedge clk);
        #1;
        sel2 = 2'd3;
        @(negedge clk);
        chk("n3_rdy_sel3", 32'(in_ready2),  32'b000);
        chk("n3_vld_held", 32'(out_valid2), 32'd1);
        chk("n3_dat_held", 32'(out_data2),  32'h6666);
        chk("n3_chan",     32'(out_chan2),  32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("n3_vld_drop", 32'(out_valid2), 32'd0);
        chk("n3_rdy_idle", 32'(in_ready2),  32'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
